// File: rtl/ld_block_padding_pkg.sv
// Shared encodings for the load-side bottom-edge padding block.
// Covers the config FSM states and the slot order of the loop-iteration words.
package ld_block_padding_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W     = 3'd1,
    S_H     = 3'd2,
    S_C     = 3'd3,
    S_B     = 3'd4,
    S_CALC  = 3'd5,
    S_ARMED = 3'd6
  } cfg_state_t;

  localparam logic [1:0] WORD_W = 2'd0;
  localparam logic [1:0] WORD_H = 2'd1;
  localparam logic [1:0] WORD_C = 2'd2;
  localparam logic [1:0] WORD_B = 2'd3;

  function automatic logic [1:0] word_slot(input cfg_state_t s);
    case (s)
      S_W:     word_slot = WORD_W;
      S_H:     word_slot = WORD_H;
      S_C:     word_slot = WORD_C;
      default: word_slot = WORD_B;
    endcase
  endfunction

endpackage

// File: rtl/ld_block_padding_fifo.sv
// Read-data skid FIFO between the DDR read port and the padded output stream.
// FIFO_DEPTH must be a power of two; pointers carry one extra wrap bit.
module ld_pad_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           r_wr;
  logic [AW:0]           r_rd;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (clr) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) r_mem[r_wr[AW-1:0]] <= push_data;
  end

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/ld_block_padding.sv
// Inserts bottom-edge padding rows on the DDR load path: padded-row requests are
// swallowed on the address side and replaced by zero beats on the data side.
module ld_block_padding
  import ld_block_padding_pkg::*;
#(
  parameter int IMM_WIDTH   = 16,
  parameter int LOOP_ITER_W = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_block_padding_v,
  input  logic [IMM_WIDTH-1:0]   diff_rows,
  input  logic                   cfg_loop_iter_ld_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter_ld,
  input  logic                   ld_start,
  input  logic                   addr_in_v,
  input  logic [ADDR_W-1:0]      addr_in,
  output logic                   addr_in_ready,
  output logic                   ddr_req_v,
  output logic [ADDR_W-1:0]      ddr_req_addr,
  input  logic                   ddr_req_ready,
  input  logic                   ddr_rd_v,
  input  logic [DATA_WIDTH-1:0]  ddr_rd_data,
  output logic                   ddr_rd_ready,
  output logic                   out_v,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   pad_active,
  output logic                   all_done
);
  localparam int PW = 2 * LOOP_ITER_W;

  cfg_state_t             r_state;
  logic [IMM_WIDTH-1:0]   r_rows_diff;
  logic [LOOP_ITER_W-1:0] r_dim [4];
  logic [PW-1:0]          r_legal, r_full, r_planes;
  logic [PW-1:0]          r_a_pt, r_a_plane, r_d_pt, r_d_plane;
  logic                   r_out_v, r_pad, r_done;
  logic [DATA_WIDTH-1:0]  r_out_data;

  logic [PW-1:0]         w_w, w_h, w_rd, w_legal_calc;
  logic                  w_block, w_run, w_a_legal, w_d_legal;
  logic                  w_acc, w_pop, w_pad, w_beat, w_push;
  logic                  w_full, w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_w  = PW'(r_dim[WORD_W]);
  assign w_h  = PW'(r_dim[WORD_H]);
  assign w_rd = PW'(r_rows_diff);
  // Rows to pad covering the whole plane (or more) leaves no legal points.
  assign w_legal_calc = (w_rd >= w_h) ? '0 : w_w * (w_h - w_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rows_diff <= '0;
      r_legal     <= '0;
      r_full      <= '0;
      r_planes    <= '0;
      for (int i = 0; i < 4; i++) r_dim[i] <= '0;
    end else if (cfg_block_padding_v) begin
      r_state     <= S_W;
      r_rows_diff <= diff_rows;
      r_legal     <= '0;
      r_full      <= '0;
      r_planes    <= '0;
      for (int i = 0; i < 4; i++) r_dim[i] <= '0;
    end else begin
      case (r_state)
        S_W, S_H, S_C, S_B: begin
          if (cfg_loop_iter_ld_v) begin
            r_dim[word_slot(r_state)] <= cfg_loop_iter_ld + 1'b1;
            r_state <= cfg_state_t'(r_state + 3'd1);
          end
        end
        S_CALC: begin
          r_legal  <= w_legal_calc;
          r_full   <= w_w * w_h;
          r_planes <= PW'(r_dim[WORD_C]) * PW'(r_dim[WORD_B]);
          r_state  <= S_ARMED;
        end
        default: ;
      endcase
    end
  end

  assign w_block   = (r_state == S_ARMED) && (r_rows_diff != '0);
  assign w_run     = w_block && !ld_start && !cfg_block_padding_v;
  assign w_a_legal = (r_a_pt < r_legal);
  assign w_d_legal = (r_d_pt < r_legal);
  assign w_acc     = w_run && addr_in_v && addr_in_ready;
  assign w_pop     = w_run && w_d_legal && !w_empty;
  assign w_pad     = w_run && !w_d_legal && (r_d_plane < r_planes);
  assign w_beat    = w_pop || w_pad;
  assign w_push    = w_run && ddr_rd_v && !w_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_pt     <= '0;
      r_a_plane  <= '0;
      r_d_pt     <= '0;
      r_d_plane  <= '0;
      r_out_v    <= 1'b0;
      r_pad      <= 1'b0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else if (cfg_block_padding_v || ld_start) begin
      r_a_pt     <= '0;
      r_a_plane  <= '0;
      r_d_pt     <= '0;
      r_d_plane  <= '0;
      r_out_v    <= 1'b0;
      r_pad      <= 1'b0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_acc) begin
        if (r_a_pt == r_full - 1'b1) begin
          r_a_pt    <= '0;
          r_a_plane <= r_a_plane + 1'b1;
        end else begin
          r_a_pt <= r_a_pt + 1'b1;
        end
      end
      if (w_beat) begin
        if (r_d_pt == r_full - 1'b1) begin
          r_d_pt    <= '0;
          r_d_plane <= r_d_plane + 1'b1;
        end else begin
          r_d_pt <= r_d_pt + 1'b1;
        end
      end
      r_out_v    <= w_beat;
      r_pad      <= w_pad;
      r_out_data <= w_pop ? w_head : '0;
      if (w_block && (r_d_plane == r_planes) && w_empty) r_done <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  always_comb begin
    addr_in_ready = 1'b0;
    ddr_req_v     = 1'b0;
    ddr_req_addr  = '0;
    out_v         = 1'b0;
    out_data      = '0;
    pad_active    = 1'b0;
    if (!reset) begin
      ddr_req_addr = addr_in;
      if (!w_block) begin
        addr_in_ready = ddr_req_ready;
        ddr_req_v     = addr_in_v;
        out_v         = ddr_rd_v;
        out_data      = ddr_rd_data;
      end else begin
        out_v      = r_out_v;
        out_data   = r_out_data;
        pad_active = r_pad;
        if (ld_start || cfg_block_padding_v || !w_a_legal) begin
          addr_in_ready = 1'b1;
        end else begin
          addr_in_ready = ddr_req_ready;
          ddr_req_v     = addr_in_v;
        end
      end
    end
  end

  assign ddr_rd_ready = !w_full;
  assign all_done     = r_done;

  ld_pad_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr      (ld_start || cfg_block_padding_v),
    .push     (w_push),
    .push_data(ddr_rd_data),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

endmodule

// File: tb/tb_ld_block_padding.sv
// Directed bench for ld_block_padding: a small DDR model plus hand-derived
// expected beat sequences for a 4x3x2x1 load with one padded bottom row.
module tb_ld_block_padding;
  localparam int NREQ = 24;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk, reset;
  logic        cfg_block_padding_v, cfg_loop_iter_ld_v, ld_start;
  logic [15:0] diff_rows, cfg_loop_iter_ld;
  logic        addr_in_v, addr_in_ready, ddr_req_v, ddr_req_ready;
  logic [31:0] addr_in, ddr_req_addr;
  logic        ddr_rd_v, ddr_rd_ready, out_v, pad_active, all_done;
  logic [63:0] ddr_rd_data, out_data;

  ld_block_padding dut (
    .clk(clk), .reset(reset),
    .cfg_block_padding_v(cfg_block_padding_v), .diff_rows(diff_rows),
    .cfg_loop_iter_ld_v(cfg_loop_iter_ld_v), .cfg_loop_iter_ld(cfg_loop_iter_ld),
    .ld_start(ld_start),
    .addr_in_v(addr_in_v), .addr_in(addr_in), .addr_in_ready(addr_in_ready),
    .ddr_req_v(ddr_req_v), .ddr_req_addr(ddr_req_addr), .ddr_req_ready(ddr_req_ready),
    .ddr_rd_v(ddr_rd_v), .ddr_rd_data(ddr_rd_data), .ddr_rd_ready(ddr_rd_ready),
    .out_v(out_v), .out_data(out_data), .pad_active(pad_active), .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_addr(input int i);
    return BASE + 32'(i * 8);
  endfunction

  function automatic logic [63:0] mk_data(input logic [31:0] a);
    return {32'hDA7A_0000, a};
  endfunction

  // DDR / address-generator model state
  int          cyc = 0;
  bit          gen_on = 0;
  int          req_idx = 0;
  logic [31:0] pend_addr[$];
  int          pend_t[$];
  int          rd_delay = 2;
  int          rd_hold_until = 0;
  bit          stall_mode = 0;
  int          stall_cnt = 0, stall_rdy_hi = 0, pad_lowrdy_acc = 0;
  int          ddr_cnt = 0, addr_bad = 0, bp_cnt = 0;
  int          ddr_idx_log[$];
  logic [63:0] out_log[$];
  bit          pad_log[$];
  int          done_at = -1;
  int          abort_at = 0;
  bit          abort_pend = 0, in_abort = 0;

  always @(negedge clk) begin
    cyc++;
    ld_start = 1'b0;
    if (abort_pend) begin
      ld_start      = 1'b1;
      abort_pend    = 0;
      in_abort      = 1;
      addr_in_v     = 1'b0;
      ddr_rd_v      = 1'b0;
      ddr_req_ready = 1'b1;
      pend_addr.delete(); pend_t.delete();
      out_log.delete(); pad_log.delete(); ddr_idx_log.delete();
      req_idx = 0; ddr_cnt = 0; done_at = -1;
    end else begin
      in_abort      = 0;
      addr_in_v     = gen_on && (req_idx < NREQ);
      addr_in       = req_addr(req_idx);
      ddr_req_ready = 1'b1;
      if (stall_mode) begin
        if ((req_idx % 12) >= 8) ddr_req_ready = 1'b0;
        else if (req_idx == 5 && stall_cnt < 6) begin
          ddr_req_ready = 1'b0;
          stall_cnt++;
        end
      end
      ddr_rd_v    = (pend_addr.size() > 0) && (cyc >= pend_t[0]) && (cyc >= rd_hold_until);
      ddr_rd_data = ddr_rd_v ? mk_data(pend_addr[0]) : 64'd0;
    end
    #1;
    if (!in_abort) begin
      if (stall_mode && addr_in_v && !ddr_req_ready && req_idx == 5 && addr_in_ready) stall_rdy_hi++;
      if (addr_in_v && !ddr_req_ready && addr_in_ready && (req_idx % 12) >= 8) pad_lowrdy_acc++;
      if (ddr_req_v && ddr_req_ready) begin
        ddr_idx_log.push_back(req_idx);
        if (ddr_req_addr !== req_addr(req_idx)) addr_bad++;
        pend_addr.push_back(ddr_req_addr);
        pend_t.push_back(cyc + rd_delay);
        ddr_cnt++;
      end
      if (addr_in_v && addr_in_ready) req_idx++;
      if (ddr_rd_v) begin
        if (ddr_rd_ready) begin
          void'(pend_addr.pop_front());
          void'(pend_t.pop_front());
        end else bp_cnt++;
      end
      if (out_v) begin
        out_log.push_back(out_data);
        pad_log.push_back(pad_active);
        if (abort_at > 0 && out_log.size() == abort_at) begin
          abort_pend = 1;
          abort_at   = 0;
        end
      end
      if (all_done && done_at < 0) done_at = out_log.size();
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    req_idx = 0;
    pend_addr.delete(); pend_t.delete();
    out_log.delete(); pad_log.delete(); ddr_idx_log.delete();
    ddr_cnt = 0; addr_bad = 0; bp_cnt = 0; done_at = -1;
    stall_mode = 0; stall_cnt = 0; stall_rdy_hi = 0; pad_lowrdy_acc = 0;
    rd_hold_until = 0; abort_at = 0; abort_pend = 0;
  endtask

  task automatic configure(input logic [15:0] diff);
    int words[4] = '{3, 2, 1, 0};
    tick;
    cfg_block_padding_v = 1'b1;
    diff_rows = diff;
    tick;
    cfg_block_padding_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_loop_iter_ld_v = 1'b1;
      cfg_loop_iter_ld   = 16'(words[i]);
      tick;
    end
    cfg_loop_iter_ld_v = 1'b0;
    repeat (3) tick;
  endtask

  task automatic start_run(input logic [15:0] diff);
    gen_on = 0;
    configure(diff);
    clear_model;
    gen_on = 1;
  endtask

  task automatic wait_beats(input string tag);
    int k = 0;
    while ((abort_at != 0 || abort_pend || out_log.size() < NREQ) && k < 600) begin
      tick;
      k++;
    end
    repeat (4) tick;
    chk({tag, " beats"}, 64'(out_log.size()), 64'(NREQ));
  endtask

  task automatic check_seq(input string tag, input bit padded);
    for (int i = 0; i < NREQ && i < out_log.size(); i++) begin
      int pl = i / 12;
      int pt = i % 12;
      logic [63:0] ed;
      bit ep;
      if (!padded)      begin ed = mk_data(req_addr(i));           ep = 0; end
      else if (pt < 8)  begin ed = mk_data(req_addr(pl * 12 + pt)); ep = 0; end
      else              begin ed = 64'd0;                          ep = 1; end
      chk($sformatf("%s data[%0d]", tag, i), out_log[i], ed);
      chk($sformatf("%s pad[%0d]", tag, i), 64'(pad_log[i]), 64'(ep));
    end
  endtask

  task automatic check_padded_run(input string tag);
    wait_beats(tag);
    chk({tag, " ddr_reqs"}, 64'(ddr_cnt), 64'd16);
    chk({tag, " addr_bad"}, 64'(addr_bad), 64'd0);
    for (int k = 0; k < 16 && k < ddr_idx_log.size(); k++)
      chk($sformatf("%s ddr_idx[%0d]", tag, k), 64'(ddr_idx_log[k]), 64'(k < 8 ? k : k + 4));
    check_seq(tag, 1);
    chk({tag, " done_at"}, 64'(done_at), 64'(NREQ));
    chk({tag, " all_done"}, 64'(all_done), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=still running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_block_padding_v = 0; cfg_loop_iter_ld_v = 0; ld_start = 0;
    diff_rows = 0; cfg_loop_iter_ld = 0;
    addr_in_v = 0; addr_in = 0; ddr_req_ready = 1; ddr_rd_v = 0; ddr_rd_data = 0;
    repeat (3) tick;
    chk("rst out_v", 64'(out_v), 64'd0);
    chk("rst pad_active", 64'(pad_active), 64'd0);
    chk("rst all_done", 64'(all_done), 64'd0);
    chk("rst ddr_rd_ready", 64'(ddr_rd_ready), 64'd1);
    chk("rst addr_in_ready", 64'(addr_in_ready), 64'd0);
    chk("rst ddr_req_v", 64'(ddr_req_v), 64'd0);
    reset = 1'b0;
    tick;

    // basic padded load
    start_run(16'd1);
    check_padded_run("basic");

    // diff_rows=0: transparent
    start_run(16'd0);
    wait_beats("bypass");
    chk("bypass ddr_reqs", 64'(ddr_cnt), 64'(NREQ));
    check_seq("bypass", 0);

    // late DDR data, back-pressure while pads drain
    start_run(16'd1);
    rd_hold_until = cyc + 40;
    check_padded_run("late");
    chk("late backpressure seen", 64'(bp_cnt > 0), 64'd1);

    // request stall at a_pt=5, pads accepted with ddr_req_ready low
    start_run(16'd1);
    stall_mode = 1;
    check_padded_run("stall");
    chk("stall cycles", 64'(stall_cnt), 64'd6);
    chk("stall addr_in_ready high", 64'(stall_rdy_hi), 64'd0);
    chk("pad accepts w/o ready", 64'(pad_lowrdy_acc), 64'd8);

    // ld_start after 10 beats, then a clean rerun
    start_run(16'd1);
    abort_at = 10;
    check_padded_run("restart");

    // async reset mid-plane
    start_run(16'd1);
    begin
      int k = 0;
      while (out_log.size() < 5 && k < 200) begin tick; k++; end
      chk("prereset beats", 64'(out_log.size() >= 5), 64'd1);
    end
    @(posedge clk);
    #2;
    gen_on = 0;
    reset  = 1'b1;
    #1;
    chk("arst out_v", 64'(out_v), 64'd0);
    chk("arst out_data", out_data, 64'd0);
    chk("arst pad_active", 64'(pad_active), 64'd0);
    chk("arst all_done", 64'(all_done), 64'd0);
    chk("arst ddr_req_v", 64'(ddr_req_v), 64'd0);
    chk("arst addr_in_ready", 64'(addr_in_ready), 64'd0);
    chk("arst ddr_rd_ready", 64'(ddr_rd_ready), 64'd1);
    tick;
    clear_model;
    tick;
    reset = 1'b0;
    start_run(16'd1);
    check_padded_run("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
